store_size_ctrl: RTL and testbench
==================================

# store_size_ctrl

Store-side counterpart of the memory data register path: where loaded words fan out from memory to the load-size and sign-extend logic, this block carries register data into memory for `sw`, `sh` and `sb`. Full-word stores are written directly. Halfword and byte stores run a read-modify-write sequence against the synchronous data memory so that the untouched bits of the word are preserved. It sits between the control unit (which issues `start`) and the data-memory port, and takes its data from the B register.

## Interface
- No parameters; all data paths are 32 bits, fixed.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; takes effect on the rising edge of `clk`.
- `start`  in  1  one-cycle request from the control unit; sampled only in IDLE.
- `store_op`  in  2  operation select: 00 = `sw`, 01 = `sh`, 10 = `sb`, 11 = illegal.
- `addr_in`  in  32  store address from the ALUOut register.
- `reg_data`  in  32  store data from the B register.
- `mem_rdata`  in  32  memory read data; valid in the cycle after `mem_addr` is presented.
- `mem_addr`  out  32  memory address.
- `mem_wr`  out  1  memory write enable.
- `mem_wdata`  out  32  memory write data.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse, coincident with `done`, for an illegal `store_op`.

## Operation
- On `start` in IDLE the block latches `addr_in`, `reg_data` and `store_op` into internal registers. The inputs are don't-care after that cycle.
- States: IDLE, RD_REQ, RD_WAIT, WR, DONE.
- Transitions:
  - IDLE + `start` + op 00 -> WR.
  - IDLE + `start` + op 01 or 10 -> RD_REQ.
  - IDLE + `start` + op 11 -> DONE, with `err` set and no memory access.
  - RD_REQ -> RD_WAIT -> WR -> DONE -> IDLE.
- `mem_addr` equals the latched address in RD_REQ, RD_WAIT and WR. It equals 0 in IDLE and DONE.
- RD_WAIT captures `mem_rdata` into the internal word register on its closing edge.
- Merge rules in WR (lane fixed at the low end; `addr_in[1:0]` is not used for lane select and is passed through unchanged):
  - `sw`: `mem_wdata` = `reg_data`.
  - `sh`: `mem_wdata` = {captured[31:16], `reg_data`[15:0]}.
  - `sb`: `mem_wdata` = {captured[31:8], `reg_data`[7:0]}.
- `mem_wr` is 1 only in WR. `mem_wdata` is 0 outside WR.
- `start` while `busy` is ignored and not queued.
- `start` in the same cycle as `done` is ignored. A new request is accepted in the following IDLE cycle at the earliest.
- All outputs are decoded from registered state and registers only. There is no combinational path from any input to any output.

## Timing
- Reset values: state IDLE; `mem_addr`=0, `mem_wr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `err`=0; internal address, data, op and captured-word registers all 0.
- Cycle numbering: cycle 0 is the cycle in which `start` is sampled high.
- `sw`: WR in cycle 1 (`mem_wr`=1); `done` in cycle 2; IDLE again in cycle 3.
- `sh`/`sb`:
  - RD_REQ in cycle 1.
  - RD_WAIT in cycle 2 (`mem_rdata` valid and captured).
  - WR in cycle 3.
  - `done` in cycle 4.
- Illegal op: `done`=`err`=1 in cycle 1; `mem_wr` stays 0 throughout.
- `busy` is high from cycle 1 through the `done` cycle inclusive.
- Reset mid-operation, including in WR: state is IDLE on the next edge, `mem_wr`=0 from that edge, no `done` is produced, and the request is dropped.

## Test plan
- `sw`: `addr_in`=0x40, `reg_data`=0xDEADBEEF -> `mem_wr`=1 in cycle 1 with `mem_addr`=0x40 and `mem_wdata`=0xDEADBEEF; `done` in cycle 2.
- `sb`: memory word 0x11223344, `reg_data`=0xFFFFFFAB -> read in cycles 1–2; write 0x112233AB in cycle 3; `done` in cycle 4.
- `sh`: memory word 0xCAFEF00D, `reg_data`=0x00001234 -> write 0xCAFE1234 in cycle 3; `busy` high in cycles 1–4.
- Illegal op 11 -> `done`=`err`=1 in cycle 1, `mem_wr` never asserted; `start` held high throughout an `sb` sequence -> exactly one write and one `done`.
- `reset` asserted while the FSM is in WR of an `sh` -> `mem_wr`=0 and `busy`=0 on the next edge, no `done`; a following `sw` completes normally.

Source files
------------

// File: rtl/store_size_ctrl.sv
// store_size_ctrl: carries B-register data into data memory for sw/sh/sb.
// Full words are written directly. Halfword and byte stores read the target
// word first, merge the new low lane into it, then write it back.
module store_size_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  store_op,
    input  logic [31:0] addr_in,
    input  logic [31:0] reg_data,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR      = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [1:0] OP_SW  = 2'b00;
    localparam logic [1:0] OP_SH  = 2'b01;
    localparam logic [1:0] OP_SB  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] word_q, word_d;

    // Merge the store data into the captured word; the lane is always the
    // low end of the word, the address low bits do not steer it.
    function automatic logic [31:0] merge_wdata(input logic [1:0]  op,
                                                input logic [31:0] data,
                                                input logic [31:0] word);
        logic [31:0] res;
        case (op)
            OP_SH:   res = {word[31:16], data[15:0]};
            OP_SB:   res = {word[31:8], data[7:0]};
            default: res = data;
        endcase
        return res;
    endfunction

    // State and request registers, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            op_q    <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            op_q    <= op_d;
            word_q  <= word_d;
        end
    end

    // Latch the request when accepted in IDLE; capture read data in RD_WAIT
    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        op_d   = op_q;
        word_d = word_q;
        if (state_q == S_IDLE && start) begin
            addr_d = addr_in;
            data_d = reg_data;
            op_d   = store_op;
        end
        if (state_q == S_RD_WAIT) begin
            word_d = mem_rdata;
        end
    end

    // Next-state decode; start is only looked at in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (store_op)
                        OP_SW:   state_d = S_WR;
                        OP_SH:   state_d = S_RD_REQ;
                        OP_SB:   state_d = S_RD_REQ;
                        default: state_d = S_DONE;
                    endcase
                end
            end
            S_RD_REQ:  state_d = S_RD_WAIT;
            S_RD_WAIT: state_d = S_WR;
            S_WR:      state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs decoded purely from registered state and latched request
    always_comb begin
        mem_addr  = '0;
        mem_wr    = 1'b0;
        mem_wdata = '0;
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        err       = (state_q == S_DONE) && (op_q == OP_ILL);
        case (state_q)
            S_RD_REQ, S_RD_WAIT: mem_addr = addr_q;
            S_WR: begin
                mem_addr  = addr_q;
                mem_wr    = 1'b1;
                mem_wdata = merge_wdata(op_q, data_q, word_q);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_store_size_ctrl.sv
// Directed bench for store_size_ctrl with a one-word synchronous memory model.
module tb_store_size_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  store_op = 2'b00;
    logic [31:0] addr_in = '0;
    logic [31:0] reg_data = '0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;

    logic [31:0] mem_word_addr = '0;
    logic [31:0] mem_word = '0;

    int n_checks = 0;
    int n_fail = 0;
    int wr_cnt;
    int done_cnt;

    store_size_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .store_op  (store_op),
        .addr_in   (addr_in),
        .reg_data  (reg_data),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Synchronous read memory holding a single known word
    always @(posedge clk)
        mem_rdata <= (mem_addr == mem_word_addr) ? mem_word : 32'hBAD0BAD0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_done"}, {31'b0, done}, 32'd0);
        chk({tag, "_wr"},   {31'b0, mem_wr}, 32'd0);
        chk({tag, "_addr"}, mem_addr, 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_err"},  {31'b0, err}, 32'd0);
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
        store_op = op;
        addr_in  = a;
        reg_data = d;
        start    = 1'b1;
        tick();                 // now in cycle 1
        start    = 1'b0;
        addr_in  = 32'h5A5A5A5A; // inputs are don't-care after acceptance
        reg_data = 32'hA5A5A5A5;
        store_op = 2'b00;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk_idle("rst");
        reset = 1'b0;
        tick();
        chk_idle("post_rst");

        // sw: direct write
        issue(2'b00, 32'h40, 32'hDEADBEEF);
        chk("sw_c1_wr", {31'b0, mem_wr}, 32'd1);
        chk("sw_c1_addr", mem_addr, 32'h40);
        chk("sw_c1_wdata", mem_wdata, 32'hDEADBEEF);
        chk("sw_c1_busy", {31'b0, busy}, 32'd1);
        chk("sw_c1_done", {31'b0, done}, 32'd0);
        tick();
        chk("sw_c2_done", {31'b0, done}, 32'd1);
        chk("sw_c2_err", {31'b0, err}, 32'd0);
        chk("sw_c2_busy", {31'b0, busy}, 32'd1);
        chk("sw_c2_wr", {31'b0, mem_wr}, 32'd0);
        chk("sw_c2_addr", mem_addr, 32'd0);
        tick();
        chk_idle("sw_c3");

        // sb: read-modify-write of low byte
        mem_word_addr = 32'h100;
        mem_word      = 32'h11223344;
        issue(2'b10, 32'h100, 32'hFFFFFFAB);
        chk("sb_c1_addr", mem_addr, 32'h100);
        chk("sb_c1_wr", {31'b0, mem_wr}, 32'd0);
        chk("sb_c1_busy", {31'b0, busy}, 32'd1);
        tick();
        chk("sb_c2_addr", mem_addr, 32'h100);
        chk("sb_c2_wr", {31'b0, mem_wr}, 32'd0);
        chk("sb_c2_rdata", mem_rdata, 32'h11223344);
        tick();
        chk("sb_c3_wr", {31'b0, mem_wr}, 32'd1);
        chk("sb_c3_addr", mem_addr, 32'h100);
        chk("sb_c3_wdata", mem_wdata, 32'h112233AB);
        tick();
        chk("sb_c4_done", {31'b0, done}, 32'd1);
        chk("sb_c4_err", {31'b0, err}, 32'd0);
        chk("sb_c4_wdata", mem_wdata, 32'd0);
        tick();
        chk_idle("sb_c5");

        // sh: low bits of the address pass through, lane fixed low
        mem_word_addr = 32'h206;
        mem_word      = 32'hCAFEF00D;
        issue(2'b01, 32'h206, 32'h00001234);
        chk("sh_c1_busy", {31'b0, busy}, 32'd1);
        chk("sh_c1_addr", mem_addr, 32'h206);
        tick();
        chk("sh_c2_busy", {31'b0, busy}, 32'd1);
        tick();
        chk("sh_c3_busy", {31'b0, busy}, 32'd1);
        chk("sh_c3_wr", {31'b0, mem_wr}, 32'd1);
        chk("sh_c3_addr", mem_addr, 32'h206);
        chk("sh_c3_wdata", mem_wdata, 32'hCAFE1234);
        tick();
        chk("sh_c4_busy", {31'b0, busy}, 32'd1);
        chk("sh_c4_done", {31'b0, done}, 32'd1);
        tick();
        chk_idle("sh_c5");

        // Illegal op: immediate done+err, no memory access
        issue(2'b11, 32'h300, 32'h12345678);
        chk("ill_c1_done", {31'b0, done}, 32'd1);
        chk("ill_c1_err", {31'b0, err}, 32'd1);
        chk("ill_c1_busy", {31'b0, busy}, 32'd1);
        chk("ill_c1_wr", {31'b0, mem_wr}, 32'd0);
        chk("ill_c1_addr", mem_addr, 32'd0);
        tick();
        chk_idle("ill_c2");

        // start held high across an sb: one write, one done, no re-accept at done
        mem_word_addr = 32'h44;
        mem_word      = 32'h01020304;
        store_op = 2'b10;
        addr_in  = 32'h44;
        reg_data = 32'h000000EE;
        start    = 1'b1;
        wr_cnt   = 0;
        done_cnt = 0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (mem_wr) wr_cnt++;
            if (done) done_cnt++;
            if (mem_wr) chk("hold_wdata", mem_wdata, 32'h010203EE);
        end
        tick();                 // cycle 5: back in IDLE despite start high
        chk("hold_c5_busy", {31'b0, busy}, 32'd0);
        start = 1'b0;
        chk("hold_wr_cnt", wr_cnt, 32'd1);
        chk("hold_done_cnt", done_cnt, 32'd1);
        tick();
        chk_idle("hold_c6");

        // Reset while in WR of an sh drops the request
        mem_word_addr = 32'h80;
        mem_word      = 32'hFFFF0000;
        issue(2'b01, 32'h80, 32'h0000ABCD);
        tick();
        tick();                 // cycle 3: WR
        chk("rstwr_c3_wr", {31'b0, mem_wr}, 32'd1);
        chk("rstwr_c3_wdata", mem_wdata, 32'hFFFFABCD);
        reset = 1'b1;
        tick();
        chk("rstwr_wr", {31'b0, mem_wr}, 32'd0);
        chk("rstwr_busy", {31'b0, busy}, 32'd0);
        chk("rstwr_done", {31'b0, done}, 32'd0);
        reset = 1'b0;
        tick();
        chk_idle("rstwr_after1");
        tick();
        chk_idle("rstwr_after2");

        // Following sw completes normally
        issue(2'b00, 32'h88, 32'h0BADF00D);
        chk("sw2_c1_wr", {31'b0, mem_wr}, 32'd1);
        chk("sw2_c1_addr", mem_addr, 32'h88);
        chk("sw2_c1_wdata", mem_wdata, 32'h0BADF00D);
        tick();
        chk("sw2_c2_done", {31'b0, done}, 32'd1);
        chk("sw2_c2_err", {31'b0, err}, 32'd0);
        tick();
        chk_idle("sw2_c3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
